ps2_key_encoder: RTL and testbench

Converts a raw PS/2 keyboard line (clock + data, open-collector, device-driven) into the 11-bit toggle-event word `ps2_key[10:0]` consumed by core-side key decoders. Deserializes 11-bit PS/2 frames, parses the E0/F0 prefix grammar, and emits one toggle event per key make/break. It is the transmitting end of the `ps2_key` interface: it sits between a physical PS/2 port and any core keyboard handler that watches `ps2_key[10]` for changes.

---
 rtl/ps2_pkg.sv | 36 +++
 rtl/ps2_rx_frame.sv | 110 +++++++++++
 rtl/ps2_key_encoder.sv | 111 +++++++++++
 tb/tb_ps2_key_encoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 key encoder shared types and constants.
// Prefix FSM states, prefix bytes, IDLE drop list, frame sizing.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } state_e;

  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_E1 = 8'hE1;

  // Controller/BAT responses ignored between keys.
  localparam logic [7:0] DROP_LIST [7] = '{
    8'h00, 8'hAA, 8'hEE, 8'hFA,
    8'hFC, 8'hFE, 8'hFF
  };

  localparam int PS2_FRAME_BITS = 11;
  localparam int PAUSE_SKIP     = 7;

  function automatic logic is_drop(
    input logic [7:0] b
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 7; i++)
      if (b == DROP_LIST[i]) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: sync, clock glitch filter, deserializer, timeout.
// In: clk_sys, reset, ps2_clk_in, ps2_dat_in. Out: byte_data, byte_valid, byte_err.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 24000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0] LAST_BIT =
    4'(PS2_FRAME_BITS - 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q, filt_d, filt_prev_q;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          clk_s, dat_s, fall;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  assign fall  = filt_prev_q & ~filt_q;

  // Level flips only after FILTER_LEN differing samples in a row.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1))
        filt_d = clk_s;
      else
        filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    to_cnt_d  = to_cnt_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd0) begin
        if (dat_s) err_d = 1'b1;
        else       bit_cnt_d = 4'd1;
      end else if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = 4'd0;
        // shift_q holds D0..D7 + parity: odd total.
        if (^shift_q && dat_s) valid_d = 1'b1;
        else                   err_d   = 1'b1;
      end else begin
        shift_d   = {dat_s, shift_q[8:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        bit_cnt_d = 4'd0;
        to_cnt_d  = '0;
        err_d     = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      dat_sync_q  <= {dat_sync_q[0], ps2_dat_in};
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      filt_cnt_q  <= filt_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign byte_data  = shift_q[7:0];
  assign byte_valid = valid_q;
  assign byte_err   = err_q;

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard to ps2_key toggle-event word: prefix FSM + output register.
// In: clk_sys, reset, ps2_clk_in, ps2_dat_in. Out: ps2_key[10:0], frame_err.
module ps2_key_encoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 24000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  logic [7:0]  byte_data;
  logic        byte_valid, byte_err;
  state_e      state_q, state_d;
  logic [2:0]  pause_q, pause_d;
  logic [10:0] key_q, key_d;
  logic        ferr_q, ferr_d;
  logic        emit, ext, brk;

  ps2_rx_frame #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_err  (byte_err)
  );

  // Prefix flags are carried by the state itself.
  assign ext = (state_q == ST_EXT) ||
               (state_q == ST_EXT_BRK);
  assign brk = (state_q == ST_BRK) ||
               (state_q == ST_EXT_BRK);

  always_comb begin
    state_d = state_q;
    pause_d = pause_q;
    key_d   = key_q;
    ferr_d  = byte_err;
    emit    = 1'b0;
    if (byte_err) begin
      state_d = ST_IDLE;
      pause_d = 3'd0;
    end else if (byte_valid) begin
      unique case (state_q)
        ST_IDLE:
          unique case (1'b1)
            byte_data == B_E0: state_d = ST_EXT;
            byte_data == B_F0: state_d = ST_BRK;
            byte_data == B_E1: begin
              state_d = ST_PAUSE;
              pause_d = 3'd0;
            end
            is_drop(byte_data): ;
            default: emit = 1'b1;
          endcase
        ST_EXT:
          unique case (1'b1)
            byte_data == B_F0: state_d = ST_EXT_BRK;
            byte_data == B_E0: ;
            default: emit = 1'b1;
          endcase
        ST_BRK:
          if (byte_data == B_E0) state_d = ST_EXT_BRK;
          else                   emit = 1'b1;
        ST_EXT_BRK:
          if (byte_data != B_E0 && byte_data != B_F0)
            emit = 1'b1;
        ST_PAUSE:
          if (pause_q == 3'(PAUSE_SKIP - 1)) begin
            state_d = ST_IDLE;
            pause_d = 3'd0;
          end else begin
            pause_d = pause_q + 3'd1;
          end
        default: state_d = ST_IDLE;
      endcase
      if (emit) begin
        key_d   = {~key_q[10], ~brk, ext, byte_data};
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pause_q <= 3'd0;
      key_q   <= 11'h000;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pause_q <= pause_d;
      key_q   <= key_d;
      ferr_q  <= ferr_d;
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Self-checking bench for ps2_key_encoder.
// Directed plan steps, then randomized byte streams vs a byte-level model.
module tb_ps2_key_encoder;

  localparam int FL = 8;
  localparam int TO = 300;
  localparam int H  = 16;

  logic        clk_sys    = 1'b0;
  logic        reset      = 1'b1;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_dat_in = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  int n_total = 0;
  int n_pass  = 0;
  int err_cycles = 0;

  logic [10:0] m_key;
  bit          m_ext, m_brk;
  int          m_pause;
  int          m_errs = 0;

  always #5 clk_sys = ~clk_sys;

  ps2_key_encoder #(
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_key   (ps2_key),
    .frame_err (frame_err)
  );

  // Cycles with frame_err high; each error must add exactly one.
  always @(posedge clk_sys)
    if (frame_err === 1'b1) err_cycles <= err_cycles + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
  endtask

  function automatic bit dropped(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA,
                     8'hFC, 8'hFE, 8'hFF};
  endfunction

  task automatic m_clear();
    m_ext   = 0;
    m_brk   = 0;
    m_pause = 0;
  endtask

  task automatic m_error();
    m_errs++;
    m_clear();
  endtask

  // Byte-level grammar: flags accumulate until a key byte arrives.
  task automatic m_byte(input logic [7:0] b);
    if (m_pause > 0)
      m_pause--;
    else if (b == 8'hE0)
      m_ext = 1;
    else if (b == 8'hF0 && !(m_brk && !m_ext))
      m_brk = 1;
    else if (!m_ext && !m_brk && b == 8'hE1)
      m_pause = 7;
    else if (!m_ext && !m_brk && dropped(b))
      ;
    else begin
      m_key = {~m_key[10], ~m_brk, m_ext, b};
      m_clear();
    end
  endtask

  function automatic logic [10:0] fbits(
    input logic [7:0] b, input bit bp, input bit bs);
    return {~bs, (~^b) ^ bp, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits,
                           input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat_in = bits[i];
      repeat (H/2) @(negedge clk_sys);
      ps2_clk_in = 1'b0;
      repeat (H) @(negedge clk_sys);
      ps2_clk_in = 1'b1;
      repeat (H/2) @(negedge clk_sys);
    end
  endtask

  task automatic send(input logic [7:0] b,
                      input bit bp, input bit bs);
    send_bits(fbits(b, bp, bs), 11);
    if (bp || bs) m_error();
    else          m_byte(b);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_key"}, 32'(ps2_key), 32'(m_key));
    check({tag, "_err"}, err_cycles, m_errs);
  endtask

  initial begin
    m_key = 11'h000;
    m_clear();
    repeat (3) @(negedge clk_sys);
    check("rst_key", 32'(ps2_key), 32'h000);
    check("rst_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk_sys);

    // 0x1C with exact stop-edge latency.
    send_bits(fbits(8'h1C, 0, 0), 10);
    ps2_dat_in = 1'b1;
    repeat (H/2) @(negedge clk_sys);
    ps2_clk_in = 1'b0;
    repeat (FL + 3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("lat_before", 32'(ps2_key), 32'h000);
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("lat_after", 32'(ps2_key), 32'h61C);
    repeat (H - FL - 4) @(negedge clk_sys);
    ps2_clk_in = 1'b1;
    repeat (H/2) @(negedge clk_sys);
    m_byte(8'h1C);
    check_state("make1c");

    send(8'hE0, 0, 0);
    check("e0_hold", 32'(ps2_key), 32'h61C);
    send(8'hF0, 0, 0);
    check("f0_hold", 32'(ps2_key), 32'h61C);
    send(8'h75, 0, 0);
    check("ebrk75", 32'(ps2_key), 32'h175);
    check_state("ebrk75m");

    send(8'h29, 1, 0);
    check("par_key", 32'(ps2_key), 32'h175);
    check("par_err", err_cycles, 1);
    send(8'h29, 0, 0);
    check("good29", 32'(ps2_key), 32'h629);

    send_bits(fbits(8'h16, 0, 0), 4);
    repeat (TO + 40) @(negedge clk_sys);
    m_error();
    check("tmo_err", err_cycles, 2);
    send(8'h16, 0, 0);
    check("after_tmo", 32'(ps2_key), 32'h216);

    send_bits(11'h7FF, 1);
    repeat (20) @(negedge clk_sys);
    m_error();
    check_state("start1");

    send(8'hF0, 0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("mid_rst_key", 32'(ps2_key), 32'h000);
    check("mid_rst_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    m_key = 11'h000;
    m_clear();
    repeat (4) @(negedge clk_sys);
    send(8'h16, 0, 0);
    check("post_rst", 32'(ps2_key), 32'h616);

    ps2_clk_in = 1'b0;
    repeat (FL - 2) @(negedge clk_sys);
    ps2_clk_in = 1'b1;
    repeat (20) @(negedge clk_sys);
    check_state("glitch");
    send(8'hAA, 0, 0);
    check("drop_aa", 32'(ps2_key), 32'h616);
    send(8'hE1, 0, 0);
    send(8'h14, 0, 0);
    send(8'h77, 0, 0);
    send(8'hE1, 0, 0);
    send(8'hF0, 0, 0);
    send(8'h14, 0, 0);
    send(8'hF0, 0, 0);
    send(8'h77, 0, 0);
    check("pause_key", 32'(ps2_key), 32'h616);
    send(8'h1C, 0, 0);
    check("after_pause", 32'(ps2_key), 32'h21C);
    check_state("after_pause_m");

    for (int it = 0; it < 20; it++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      b = 8'($urandom_range(1, 131));
      if (r == 0)
        send(b, 1, 0);
      else if (r == 1)
        send(b, 0, 1);
      else if (r == 2) begin
        send(8'hE1, 0, 0);
        for (int k = 0; k < 7; k++)
          send(8'($urandom), 0, 0);
      end else begin
        if ($urandom_range(0, 1) == 1)
          send(8'hE0, 0, 0);
        if ($urandom_range(0, 1) == 1)
          send(8'hF0, 0, 0);
        send(b, 0, 0);
      end
      check_state($sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
